la_capture_buffer: RTL
======================

# la_capture_buffer

Single-clock logic-analyzer capture block for the Microwatt user project. It samples a probe bus from the Microwatt core into an on-chip buffer when a masked trigger pattern matches. The management core arms it, polls it and reads it out through the user-area Wishbone slave port. Firmware then reports the result on the checkbits GPIOs.

## Interface
Parameters:
- WIDTH, 32: probe bus width in bits; 1..32.
- DEPTH, 64: number of capture samples; power of two, 2..256.

Ports:
- wb_clk_i  in  1  sole clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects. Ignored: all writes are full-word.
- wb_adr_i  in  5  word-aligned byte address; bits [4:2] select the register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o = 1.
- wb_ack_o  out  1  single-cycle acknowledge.
- probe_i  in  WIDTH  signals sampled from the Microwatt core.
- irq_o  out  1  high while the block is in state DONE.

## Operation
Registers (byte offsets; unused bits read 0):
- 0x00 CTRL (W): bit0 ARM, bit1 ABORT. Both self-clearing; reads return 0.
- 0x04 STATUS (R): [1:0] state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3); [16:8] count of samples stored.
- 0x08 TRIG_MASK (RW).
- 0x0C TRIG_VALUE (RW).
- 0x10 RDADDR (RW): only the low log2(DEPTH) bits are kept, so addresses wrap modulo DEPTH.
- 0x14 RDDATA (R): buffer word at RDADDR, zero-extended to 32 bits.
- 0x18 DECIM (RW, see Configuration).

State machine:
- IDLE: on ARM, go to ARMED and clear count.
- ARMED: trigger = ((probe_i ^ TRIG_VALUE) & TRIG_MASK) == 0.
  - On trigger: store probe_i at address 0, set count=1, go to CAPTURE. If DEPTH samples are now stored, go directly to DONE instead.
  - TRIG_MASK = 0 triggers on the first ARMED cycle.
- CAPTURE: store one sample per sample tick at address count, then increment count. When count reaches DEPTH, go to DONE.
- DONE: hold. ARM restarts the sequence (go to ARMED, clear count).
- ARM received in ARMED or CAPTURE: restart at ARMED with count=0.
- ABORT in any state: go to IDLE; count and buffer contents are kept.
- ARM and ABORT in the same write: ABORT wins.
- TRIG_MASK/TRIG_VALUE writes take effect on the cycle after the ack.
- RDDATA returns the stored value for addresses below count. For addresses at or above count, data is undefined.

Wishbone:
- wb_ack_o rises the cycle after wb_cyc_i & wb_stb_i & !wb_ack_o, and lasts exactly one cycle. There is no stall and no error response.
- Back-to-back requests therefore complete every two cycles.
- Writes to read-only registers are acknowledged and ignored. Unmapped offsets read 0.

## Timing
- Reset values: wb_ack_o=0, wb_dat_o=0, irq_o=0, state=IDLE, count=0, TRIG_MASK=0, TRIG_VALUE=0, RDADDR=0, DECIM=0. Buffer contents are not reset.
- ARM is acked in cycle N. The state is ARMED from cycle N+1, and the trigger is first evaluated on probe_i in cycle N+1.
- probe_i is sampled in the same cycle the trigger compare uses; there is no input pipeline.
- The buffer read is registered from RDADDR every cycle. RDDATA is valid on any read acked at least one cycle after the RDADDR write ack.
- irq_o rises the cycle after the last sample is written. It falls the cycle after ARM or ABORT is acked.
- Reset mid-capture: the block returns to IDLE next cycle with all registers at reset values.

## Configuration
- LA_CAPTURE_DECIM_EN defined:
  - DECIM[7:0] is implemented. A divider reloads to DECIM on the trigger cycle and counts down each cycle.
  - In CAPTURE, a sample is stored when the divider is 0, so samples are DECIM+1 cycles apart.
  - The trigger sample itself is always stored at the trigger cycle.
- Undefined: DECIM reads 0, writes are ignored, and every CAPTURE cycle is a sample tick.

## Structure
- la_capture_pkg holds the register offset constants, the state encoding, and the CTRL bit positions.
- One sub-module, la_capture_mem: DEPTH×WIDTH storage with one write port and a registered read port, so a macro RAM can replace it later.
- All other logic (FSM, Wishbone decode, divider) lives in la_capture_buffer.

## Test plan
- Reset, then read all registers -> STATUS=0, TRIG_MASK=0, RDADDR=0, irq_o=0. Each ack is one cycle wide and arrives one cycle after strobe.
- Mask=0, ARM, probe_i = cycle counter -> DONE after 64 cycles, count=64. RDDATA[i] = value at ARM+1+i; irq_o=1.
- Mask=0xFF, value=0x5A, probe_i ramps from 0 -> the trigger sample is 0x5A and RDDATA[63]=0x99.
- ARM, then ABORT in CAPTURE after 10 samples -> STATUS state=IDLE, count=10, irq_o=0. Then write CTRL=0x3 -> state stays IDLE.
- During CAPTURE, ARM again -> count returns to 0 and the state is ARMED.
- With LA_CAPTURE_DECIM_EN and DECIM=3, ramp probe -> consecutive RDDATA entries differ by 4. Without the macro, DECIM reads 0 and entries differ by 1.

Source files
------------

// File: rtl/la_capture_pkg.sv
// -----------------------------------------------------------------------------
// la_capture_pkg
// Shared definitions for the logic-analyzer capture block: Wishbone register
// word offsets (wb_adr_i[4:2]), capture state encoding and CTRL bit positions.
// -----------------------------------------------------------------------------
package la_capture_pkg;

    // Capture state; the encoding is visible to firmware in STATUS[1:0].
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } la_state_e;

    // Register word offsets (byte offset >> 2).
    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_STATUS     = 3'd1;
    localparam logic [2:0] REG_TRIG_MASK  = 3'd2;
    localparam logic [2:0] REG_TRIG_VALUE = 3'd3;
    localparam logic [2:0] REG_RDADDR     = 3'd4;
    localparam logic [2:0] REG_RDDATA     = 3'd5;
    localparam logic [2:0] REG_DECIM      = 3'd6;

    // CTRL command bits (self-clearing).
    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_ABORT_BIT = 1;

endpackage

// File: rtl/la_capture_mem.sv
// -----------------------------------------------------------------------------
// la_capture_mem
// DEPTH x WIDTH sample storage: one synchronous write port and one registered
// read port, shaped so a macro RAM can be dropped in later.
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (sampled every cycle)
//   o_rdata  read data, one cycle after i_raddr
// -----------------------------------------------------------------------------
module la_capture_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the storage array has no reset; clearing it would block mapping
    // onto RAM, and firmware never reads entries at or above count.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/la_capture_buffer.sv
// -----------------------------------------------------------------------------
// la_capture_buffer
// Logic-analyzer capture block. Samples probe_i into an on-chip buffer after a
// masked trigger match; armed, polled and read out over a Wishbone slave.
//   wb_clk_i / wb_rst_i        clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i/sel_i  Wishbone request (sel ignored, full-word only)
//   wb_adr_i[4:2]              register select
//   wb_dat_i / wb_dat_o        write / read data (read valid with wb_ack_o)
//   wb_ack_o                   single-cycle acknowledge
//   probe_i                    probe bus from the Microwatt core
//   irq_o                      high while in DONE
// Optional feature: define LA_CAPTURE_DECIM_EN for the DECIM sample divider.
// -----------------------------------------------------------------------------
module la_capture_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] probe_i,
    output logic             irq_o
);
    import la_capture_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;               // count must reach DEPTH itself
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    la_state_e        r_state, w_state_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic             r_ack;
    logic [31:0]      r_trig_mask;
    logic [31:0]      r_trig_value;
    logic [AW-1:0]    r_rdaddr;

    logic             w_req, w_wr, w_arm, w_abort, w_trig, w_tick;
    logic             w_mem_we, w_div_load;
    logic [2:0]       w_sel;
    logic [AW-1:0]    w_mem_waddr;
    logic [WIDTH-1:0] w_mem_q;
    logic [31:0]      w_rd_data;
    logic             w_unused;

    assign w_unused = ^{wb_sel_i, wb_adr_i[1:0]};

    // ---------------- Wishbone ----------------
    // A new request is one not already being acked; writes commit at the end
    // of the ack cycle so their effect is visible the cycle after the ack.
    assign w_sel   = wb_adr_i[4:2];
    assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr    = wb_cyc_i & wb_stb_i & wb_we_i & r_ack;
    assign w_abort = w_wr && (w_sel == REG_CTRL) && wb_dat_i[CTRL_ABORT_BIT];
    assign w_arm   = w_wr && (w_sel == REG_CTRL) && wb_dat_i[CTRL_ARM_BIT];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack        <= 1'b0;
            r_trig_mask  <= '0;
            r_trig_value <= '0;
            r_rdaddr     <= '0;
        end else begin
            r_ack <= w_req;
            if (w_wr) begin
                case (w_sel)
                    REG_TRIG_MASK:  r_trig_mask  <= wb_dat_i;
                    REG_TRIG_VALUE: r_trig_value <= wb_dat_i;
                    REG_RDADDR:     r_rdaddr     <= wb_dat_i[AW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- Sample divider ----------------
`ifdef LA_CAPTURE_DECIM_EN
    logic [7:0] r_decim;
    logic [7:0] r_div;

    assign w_tick = (r_div == 8'd0);

    // Reloads on the trigger and on every stored sample, so samples land
    // DECIM+1 cycles apart.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_decim <= '0;
            r_div   <= '0;
        end else begin
            if (w_wr && (w_sel == REG_DECIM)) begin
                r_decim <= wb_dat_i[7:0];
            end
            if (w_div_load) begin
                r_div <= r_decim;
            end else if (r_state == ST_CAPTURE) begin
                r_div <= w_tick ? r_decim : r_div - 8'd1;
            end
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // ---------------- Capture FSM ----------------
    assign w_trig = (((probe_i ^ r_trig_value[WIDTH-1:0]) & r_trig_mask[WIDTH-1:0]) == '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mem_we    = 1'b0;
        w_div_load  = 1'b0;
        if (w_abort) begin
            // ABORT beats ARM; count and buffer are left for readout.
            w_state_nxt = ST_IDLE;
        end else if (w_arm) begin
            w_state_nxt = ST_ARMED;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_trig) begin
                        w_mem_we    = 1'b1;
                        w_div_load  = 1'b1;
                        w_count_nxt = CW'(1);
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_tick) begin
                        w_mem_we    = 1'b1;
                        w_count_nxt = r_count + 1'b1;
                        if (r_count == LAST_IDX) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ARM always clears count, so the trigger sample goes to address 0.
    assign w_mem_waddr = (r_state == ST_ARMED) ? '0 : r_count[AW-1:0];

    la_capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (wb_clk_i),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (probe_i),
        .i_raddr (r_rdaddr),
        .o_rdata (w_mem_q)
    );

    // ---------------- Read mux ----------------
    // Driven only during the ack cycle from registered sources; RDDATA then
    // reflects RDADDR as it stood one cycle earlier.
    always_comb begin
        w_rd_data = '0;
        if (r_ack) begin
            case (w_sel)
                REG_STATUS: begin
                    w_rd_data[1:0]     = r_state;
                    w_rd_data[8 +: CW] = r_count;
                end
                REG_TRIG_MASK:  w_rd_data = r_trig_mask;
                REG_TRIG_VALUE: w_rd_data = r_trig_value;
                REG_RDADDR:     w_rd_data[AW-1:0] = r_rdaddr;
                REG_RDDATA:     w_rd_data[WIDTH-1:0] = w_mem_q;
`ifdef LA_CAPTURE_DECIM_EN
                REG_DECIM:      w_rd_data[7:0] = r_decim;
`endif
                default: ;
            endcase
        end
    end

    assign wb_dat_o = w_rd_data;
    assign wb_ack_o = r_ack;
    assign irq_o    = (r_state == ST_DONE);

endmodule
